// File: rtl/dm_host_if.sv
// Signal bundle between dm_host_port and its environment: load stream, CPU control,
// DatMem port and result stream.
interface dm_host_if;
    // Both streams transfer a byte on a rising edge where valid and ready are both 1.
    // The producer holds valid and data steady until that transfer, and ready may
    // wait on valid.
    logic       start;
    logic       ld_valid;
    logic [7:0] ld_data;
    logic       ld_ready;
    logic       cpu_reset;
    logic       cpu_done;
    logic       mem_wr_en;
    logic       mem_rd_en;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready;
    logic       busy;
    logic       finished;
    logic       timeout_err;
    logic [2:0] state_dbg;

    modport master (
        input  start, ld_valid, ld_data, cpu_done, mem_rdata, out_ready,
        output ld_ready, cpu_reset, mem_wr_en, mem_rd_en, mem_addr, mem_wdata,
               out_valid, out_data, busy, finished, timeout_err, state_dbg
    );

    modport slave (
        output start, ld_valid, ld_data, cpu_done, mem_rdata, out_ready,
        input  ld_ready, cpu_reset, mem_wr_en, mem_rd_en, mem_addr, mem_wdata,
               out_valid, out_data, busy, finished, timeout_err, state_dbg
    );
endinterface

// File: rtl/dm_host_port.sv
// Host sequencer for the CPU: loads input bytes into DatMem, runs the CPU until Done
// or a timeout, then streams result bytes out of DatMem.
module dm_host_port #(
    parameter logic [7:0]  LD_BASE  = 8'd0,
    parameter logic [8:0]  LD_COUNT = 9'd64,
    parameter logic [7:0]  RD_BASE  = 8'd64,
    parameter logic [8:0]  RD_COUNT = 9'd32,
    parameter logic [15:0] TIMEOUT  = 16'd50000
) (
    input logic       Clk,
    input logic       Reset,
    dm_host_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_RUN   = 3'd2,
        S_FETCH = 3'd3,
        S_HOLD  = 3'd4,
        S_DONE  = 3'd5,
        S_ERR   = 3'd6
    } state_e;

    state_e      state_q, state_d;
    logic [8:0]  idx_q, idx_d;
    logic [15:0] cnt_q, cnt_d;
    logic        ld_ready_q, ld_ready_d;
    logic        cpu_reset_q, cpu_reset_d;
    logic        out_valid_q, out_valid_d;
    logic [7:0]  out_data_q, out_data_d;
    logic        busy_q, busy_d;
    logic        finished_q, finished_d;
    logic        timeout_err_q, timeout_err_d;

    logic        ld_fire;
    logic        rd_fetch;

    assign ld_fire  = bus.ld_valid & ld_ready_q;
    assign rd_fetch = (state_q == S_FETCH);

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        cnt_d         = cnt_q;
        ld_ready_d    = ld_ready_q;
        cpu_reset_d   = cpu_reset_q;
        out_valid_d   = out_valid_q;
        out_data_d    = out_data_q;
        busy_d        = busy_q;
        finished_d    = finished_q;
        timeout_err_d = timeout_err_q;

        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (bus.start) begin
                    idx_d         = 9'd0;
                    cnt_d         = 16'd0;
                    busy_d        = 1'b1;
                    finished_d    = 1'b0;
                    timeout_err_d = 1'b0;
                    cpu_reset_d   = 1'b1;
                    if (LD_COUNT == 9'd0) begin
                        state_d = S_RUN;
                    end else begin
                        state_d    = S_LOAD;
                        ld_ready_d = 1'b1;
                    end
                end
            end
            S_LOAD: begin
                if (ld_fire) begin
                    idx_d = idx_q + 9'd1;
                    if (idx_q == LD_COUNT - 9'd1) begin
                        state_d    = S_RUN;
                        ld_ready_d = 1'b0;
                    end
                end
            end
            S_RUN: begin
                // The first RUN cycle keeps the CPU in reset so its PC restarts cleanly.
                if (cpu_reset_q) begin
                    cpu_reset_d = 1'b0;
                    cnt_d       = 16'd0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                    if (bus.cpu_done) begin
                        cpu_reset_d = 1'b1;
                        idx_d       = 9'd0;
                        if (RD_COUNT == 9'd0) begin
                            state_d    = S_DONE;
                            busy_d     = 1'b0;
                            finished_d = 1'b1;
                        end else begin
                            state_d = S_FETCH;
                        end
                    end else if (cnt_q == TIMEOUT - 16'd1) begin
                        state_d       = S_ERR;
                        cpu_reset_d   = 1'b1;
                        busy_d        = 1'b0;
                        finished_d    = 1'b1;
                        timeout_err_d = 1'b1;
                    end
                end
            end
            S_FETCH: begin
                out_data_d  = bus.mem_rdata;
                out_valid_d = 1'b1;
                state_d     = S_HOLD;
            end
            S_HOLD: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    idx_d       = idx_q + 9'd1;
                    if (idx_q == RD_COUNT - 9'd1) begin
                        state_d    = S_DONE;
                        busy_d     = 1'b0;
                        finished_d = 1'b1;
                    end else begin
                        state_d = S_FETCH;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q       <= S_IDLE;
            idx_q         <= 9'd0;
            cnt_q         <= 16'd0;
            ld_ready_q    <= 1'b0;
            cpu_reset_q   <= 1'b1;
            out_valid_q   <= 1'b0;
            out_data_q    <= 8'd0;
            busy_q        <= 1'b0;
            finished_q    <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            cnt_q         <= cnt_d;
            ld_ready_q    <= ld_ready_d;
            cpu_reset_q   <= cpu_reset_d;
            out_valid_q   <= out_valid_d;
            out_data_q    <= out_data_d;
            busy_q        <= busy_d;
            finished_q    <= finished_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    // Memory strobes are combinational so a load byte is written in its handshake cycle.
    assign bus.mem_wr_en   = ld_fire;
    assign bus.mem_rd_en   = rd_fetch;
    assign bus.mem_addr    = ld_fire  ? (LD_BASE + idx_q[7:0]) :
                             rd_fetch ? (RD_BASE + idx_q[7:0]) : 8'd0;
    assign bus.mem_wdata   = ld_fire ? bus.ld_data : 8'd0;

    assign bus.ld_ready    = ld_ready_q;
    assign bus.cpu_reset   = cpu_reset_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_data    = out_data_q;
    assign bus.busy        = busy_q;
    assign bus.finished    = finished_q;
    assign bus.timeout_err = timeout_err_q;
    assign bus.state_dbg   = state_q;

endmodule
